// File: rtl/tnoc_credit_tx.sv
// Purpose : transmit end of a credit-based flit link; sends only while a credit is held.
// Latency : 1 cycle from accept (i_valid && o_ready) to o_valid/o_data on the link.
// Backpr. : o_ready = credit count != 0; the link side has no backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_clear             synchronous clear back to the reset state, beats all other events
//   i_valid/o_ready     local flit source handshake, i_data carries the flit
//   o_valid/o_data      registered link beat
//   i_credit_return     one-cycle pulse per pop at the remote FIFO
//   o_credit_count      credit counter register, o_no_credit = (count == 0)
//   o_credit_error      sticky overflow flag (returned while already full)
//
// Optional build macro: TNOC_CREDIT_TX_ERROR_CHECK_EN
//   defined   : overflow sets the sticky o_credit_error and fires a simulation assertion
//   undefined : o_credit_error is tied low; counter saturation is the same in both builds
module tnoc_credit_tx #(
  parameter  int WIDTH     = 8,
  parameter  int CREDITS   = 8,
  localparam int CNT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  input  logic                 i_credit_return,
  output logic [CNT_WIDTH-1:0] o_credit_count,
  output logic                 o_no_credit,
  output logic                 o_credit_error
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(CREDITS);

  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic                 w_ready;
  logic                 w_send;
  logic                 w_full;

  // Ready comes from the count register only, so the source never sees a
  // combinational path from its own i_valid back into o_ready.
  assign w_ready = (r_count != '0);
  assign w_send  = i_valid & w_ready;
  assign w_full  = (r_count == MAX_CNT);

  // A send and a return in the same cycle cancel. A return while already full
  // is an overflow: the count saturates rather than wrapping.
  always_comb begin
    w_count_nxt = r_count;
    if (w_send && !i_credit_return) begin
      w_count_nxt = r_count - CNT_WIDTH'(1);
    end else if (!w_send && i_credit_return && !w_full) begin
      w_count_nxt = r_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= MAX_CNT;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      // Clear drops any send/return presented this cycle; the remote FIFO is
      // cleared in lockstep, so all credits are home again.
      r_count <= MAX_CNT;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= w_send;
      if (w_send) begin
        r_data <= i_data;
      end
    end
  end

  assign o_ready        = w_ready;
  assign o_valid        = r_valid;
  assign o_data         = r_data;
  assign o_credit_count = r_count;
  assign o_no_credit    = ~w_ready;

`ifdef TNOC_CREDIT_TX_ERROR_CHECK_EN
  logic r_error;
  logic w_overflow;

  assign w_overflow = i_credit_return & ~w_send & w_full & ~i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (i_clear) begin
      r_error <= 1'b0;
    end else if (w_overflow) begin
      r_error <= 1'b1;
    end
  end

  assign o_credit_error = r_error;

  // Overflow means the receiver returned more credits than it was ever given.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !w_overflow)
    else $warning("tnoc_credit_tx: credit returned while count already at CREDITS");
`else
  assign o_credit_error = 1'b0;
`endif

endmodule
